// File: rtl/sha256_w_mem_for_pipeline_21_2_if.sv
// Handshake bundle between the 20_2 memory stage, the 21_2 expander stage and the round pipeline.
// The master drives the upstream data and the downstream ready; the slave is the expander stage.
interface sha256_w_mem_for_pipeline_21_2_if;
    logic         valid_in;
    logic         ready_out;
    logic [159:0] block_in;
    logic         valid_out;
    logic         ready_in;
    logic [191:0] block_out;
    logic [15:0]  blk_count;

    modport master (
        output valid_in, block_in, ready_in,
        input  ready_out, valid_out, block_out, blk_count
    );

    modport slave (
        input  valid_in, block_in, ready_in,
        output ready_out, valid_out, block_out, blk_count
    );
endinterface

// File: rtl/sha256_w_mem_for_pipeline_21_2.sv
// Message-schedule stage: appends w_new = sigma1(e) + sigma0(b) + a to the incoming {a,b,c,d,e}
// bundle and buffers results in a 2-entry FIFO so the round pipeline can stall.
module sha256_w_mem_for_pipeline_21_2 (
    input  logic                                   CLK,
    input  logic                                   RST,
    sha256_w_mem_for_pipeline_21_2_if.slave        bus
);

    function automatic logic [31:0] sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

    logic [191:0] head_q, head_d;
    logic [191:0] tail_q, tail_d;
    logic [1:0]   cnt_q, cnt_d;
    logic [15:0]  blk_count_q, blk_count_d;

    logic [31:0]  w_new;
    logic [191:0] entry_new;
    logic         push;
    logic         pop;

    assign w_new     = sigma1(bus.block_in[31:0]) + sigma0(bus.block_in[127:96]) + bus.block_in[159:128];
    assign entry_new = {bus.block_in, w_new};

    // Ready depends only on the occupancy register, never on downstream ready.
    assign bus.ready_out = (cnt_q != 2'd2);
    assign bus.valid_out = (cnt_q != 2'd0);
    assign bus.block_out = head_q;
    assign bus.blk_count = blk_count_q;

    assign push = bus.valid_in & bus.ready_out;
    assign pop  = bus.valid_out & bus.ready_in;

    always_comb begin
        head_d      = head_q;
        tail_d      = tail_q;
        cnt_d       = cnt_q;
        blk_count_d = blk_count_q;
        case ({push, pop})
            2'b10: begin
                if (cnt_q == 2'd0) begin
                    head_d = entry_new;
                end else begin
                    tail_d = entry_new;
                end
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                head_d = tail_q;
                cnt_d  = cnt_q - 2'd1;
            end
            2'b11: begin
                // Only reachable with one entry held: the new bundle replaces the departing head.
                head_d = entry_new;
            end
            default: begin
            end
        endcase
        if (pop) begin
            blk_count_d = blk_count_q + 16'd1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            head_q      <= '0;
            tail_q      <= '0;
            cnt_q       <= 2'd0;
            blk_count_q <= 16'd0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            cnt_q       <= cnt_d;
            blk_count_q <= blk_count_d;
        end
    end

endmodule

// File: tb/tb_sha256_w_mem_for_pipeline_21_2.sv
// Self-checking bench for the 21_2 expander stage: constant vectors, hand sequences and a
// queue-based reference model driven by random handshakes.
module tb_sha256_w_mem_for_pipeline_21_2;

    logic CLK;
    logic RST;

    sha256_w_mem_for_pipeline_21_2_if bus ();

    sha256_w_mem_for_pipeline_21_2 dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int unsigned tests_run = 0;
    int unsigned tests_failed = 0;

    logic [191:0] model_q[$];
    logic [15:0]  exp_count;

    typedef struct {
        logic [31:0] a, b, c, d, e;
        logic [31:0] exp_w;
    } vec_t;

    vec_t vecs[5];

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        logic [63:0] dbl;
        dbl = {x, x} >> n;
        return dbl[31:0];
    endfunction

    function automatic logic [31:0] ref_w(input logic [159:0] blk);
        logic [31:0] a, b, e, s0, s1;
        a  = blk[159:128];
        b  = blk[127:96];
        e  = blk[31:0];
        s0 = rotr(b, 7) ^ rotr(b, 18) ^ (b >> 3);
        s1 = rotr(e, 17) ^ rotr(e, 19) ^ (e >> 10);
        return 32'((64'(s1) + 64'(s0) + 64'(a)) % 64'h1_0000_0000);
    endfunction

    function automatic logic [159:0] rand_blk();
        return {$urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check(input string name, input logic [191:0] got, input logic [191:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check_state();
        check("ready_out", 192'(bus.ready_out), 192'(model_q.size() != 2));
        check("valid_out", 192'(bus.valid_out), 192'(model_q.size() != 0));
        if (model_q.size() != 0) check("block_out", bus.block_out, model_q[0]);
        check("blk_count", 192'(bus.blk_count), 192'(exp_count));
    endtask

    // One clock cycle: check outputs, predict the transfers, clock, then update the model.
    task automatic tick();
        bit push, pop, stall;
        logic [191:0] entry, prev;
        check_state();
        push  = bus.valid_in && (model_q.size() < 2);
        pop   = (model_q.size() != 0) && bus.ready_in;
        stall = (model_q.size() != 0) && !bus.ready_in;
        entry = {bus.block_in, ref_w(bus.block_in)};
        prev  = bus.block_out;
        @(posedge CLK);
        #1;
        if (pop) begin
            void'(model_q.pop_front());
            exp_count++;
        end
        if (push) model_q.push_back(entry);
        if (stall) check("stall_stable", bus.block_out, prev);
    endtask

    // Asserts reset away from any clock edge and checks outputs clear before the next edge.
    task automatic do_reset();
        bus.valid_in = 1'b0;
        RST = 1'b0;
        #1;
        check("rst_valid_out", 192'(bus.valid_out), 192'(0));
        check("rst_ready_out", 192'(bus.ready_out), 192'(1));
        check("rst_blk_count", 192'(bus.blk_count), 192'(0));
        check("rst_block_out", bus.block_out, 192'(0));
        @(posedge CLK);
        #1;
        RST = 1'b1;
        model_q.delete();
        exp_count = 16'd0;
    endtask

    initial begin
        logic [159:0] x0, x1, x2, blk;

        vecs[0] = '{32'h80000000, 32'h00000001, 32'h0, 32'h0, 32'h00000001, 32'h8200E000};
        vecs[1] = '{32'hFFFFFFFF, 32'h00000000, 32'h0, 32'h0, 32'h00000001, 32'h00009FFF};
        vecs[2] = '{32'h00000000, 32'h00000001, 32'h0, 32'h0, 32'h00000000, 32'h02004000};
        vecs[3] = '{32'h00000000, 32'h00000000, 32'h0, 32'h0, 32'h00000001, 32'h0000A000};
        vecs[4] = '{32'h12345678, 32'h00000000, 32'h9, 32'h7, 32'h00000000, 32'h12345678};

        RST = 1'b1;
        bus.valid_in = 1'b0;
        bus.ready_in = 1'b0;
        bus.block_in = '0;
        exp_count = 16'd0;
        #3;
        do_reset();

        // Constant vectors: single transfer, one-cycle latency, then drain.
        for (int i = 0; i < 5; i++) begin
            blk = {vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].d, vecs[i].e};
            bus.block_in = blk;
            bus.valid_in = 1'b1;
            bus.ready_in = 1'b0;
            tick();
            bus.valid_in = 1'b0;
            check($sformatf("vec%0d_valid", i), 192'(bus.valid_out), 192'(1));
            check($sformatf("vec%0d_w", i), 192'(bus.block_out[31:0]), 192'(vecs[i].exp_w));
            check($sformatf("vec%0d_upper", i), 192'(bus.block_out[191:32]), 192'(blk));
            bus.ready_in = 1'b1;
            tick();
            check($sformatf("vec%0d_count", i), 192'(bus.blk_count), 192'(i + 1));
        end

        // Backpressure: two bundles absorbed, third held upstream, then drained in order.
        do_reset();
        x0 = rand_blk(); x1 = rand_blk(); x2 = rand_blk();
        bus.ready_in = 1'b0;
        bus.valid_in = 1'b1;
        bus.block_in = x0; tick();
        bus.block_in = x1; tick();
        bus.block_in = x2;
        check("bp_ready_low", 192'(bus.ready_out), 192'(0));
        tick();
        check("bp_ready_still_low", 192'(bus.ready_out), 192'(0));
        check("bp_head_x0", bus.block_out, {x0, ref_w(x0)});
        bus.ready_in = 1'b1;
        tick();
        check("bp_out_x1", bus.block_out, {x1, ref_w(x1)});
        check("bp_ready_back", 192'(bus.ready_out), 192'(1));
        tick();
        bus.valid_in = 1'b0;
        check("bp_out_x2", bus.block_out, {x2, ref_w(x2)});
        check("bp_no_gap", 192'(bus.valid_out), 192'(1));
        tick();
        check("bp_count", 192'(bus.blk_count), 192'(3));

        // Streaming: 100 bundles at full rate, occupancy never reaches two.
        do_reset();
        bus.ready_in = 1'b1;
        bus.valid_in = 1'b1;
        for (int i = 0; i < 100; i++) begin
            bus.block_in = rand_blk();
            tick();
            if (model_q.size() > 1 || bus.ready_out !== 1'b1)
                check("stream_occupancy", 192'(bus.ready_out), 192'(1));
        end
        bus.valid_in = 1'b0;
        tick();
        check("stream_count", 192'(bus.blk_count), 192'(100));

        // Randomized handshake with a mid-stream asynchronous reset.
        for (int i = 0; i < 10000; i++) begin
            bus.valid_in = 1'($urandom_range(0, 1));
            bus.ready_in = 1'($urandom_range(0, 1));
            bus.block_in = rand_blk();
            if (i == 5000) do_reset();
            tick();
        end

        // Counter wrap: 65536 output transfers bring blk_count back to zero.
        do_reset();
        bus.ready_in = 1'b1;
        bus.valid_in = 1'b1;
        for (int i = 0; i < 65536; i++) begin
            bus.block_in = rand_blk();
            tick();
        end
        bus.valid_in = 1'b0;
        check("wrap_before_last", 192'(bus.blk_count), 192'(16'hFFFF));
        tick();
        check("wrap_count", 192'(bus.blk_count), 192'(16'h0000));
        check("wrap_empty", 192'(bus.valid_out), 192'(0));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/sha256_w_mem_for_pipeline_21_2.md
# sha256_w_mem_for_pipeline_21_2

Pipeline stage of the double-SHA256 Compact Message Expander, directly downstream of the 20_2 memory stage. It accepts the 160-bit word bundle produced by stage 20_2 and appends the next message-schedule word. It buffers up to two results behind a valid/ready handshake so the round pipeline can stall without losing data. It also counts completed output transfers for debug and performance monitoring.

## Interface
- No parameters; all widths are fixed.
- CLK  input  1  single clock; all state updates on rising edge.
- RST  input  1  asynchronous, active-low reset.
- valid_in  input  1  upstream word bundle on block_in is valid.
- ready_out  output  1  stage can accept a bundle this cycle.
- block_in  input  160  {a,b,c,d,e}, 32 bits each, a = [159:128], e = [31:0].
- valid_out  output  1  block_out holds a valid bundle.
- ready_in  input  1  downstream accepts block_out this cycle.
- block_out  output  192  {a,b,c,d,e,w_new}; w_new = [31:0].
- blk_count  output  16  number of completed output transfers, modulo 2^16.

## Operation
- σ0(x) = ROTR7(x) ^ ROTR18(x) ^ SHR3(x).
- σ1(x) = ROTR17(x) ^ ROTR19(x) ^ SHR10(x).
- w_new = σ1(e) + σ0(b) + a, computed modulo 2^32 with carries discarded. It is computed combinationally from block_in at the point of capture.
- Input transfer happens when valid_in & ready_out. Output transfer happens when valid_out & ready_in.
- Storage is a 2-entry FIFO holding 192-bit entries: head register H, tail register T, and a 2-bit occupancy count N in the range 0..2.
- ready_out = (N != 2), decoded from registered state only. It has no combinational path from ready_in.
- valid_out = (N != 0). block_out = H.
- Update rules, per cycle:
  - Push only: if N = 0, write to H; if N = 1, write to T. N increments.
  - Pop only: H <= T and N decrements. T contents become don't-care.
  - Push and pop with N = 1: H <= new entry, N stays at 1.
  - Push and pop with N = 2: cannot occur, because ready_out = 0 when N = 2.
  - Neither: hold all state.
- Ordering is strict FIFO. No reordering and no drops.
- blk_count increments by 1 on every output transfer and wraps from 0xFFFF to 0x0000.
- block_in is ignored when valid_in = 0. valid_in asserted while ready_out = 0 has no effect; upstream must hold the bundle.

## Timing
- Reset (RST = 0, asynchronous):
  - N = 0, so valid_out = 0 and ready_out = 1 immediately.
  - blk_count = 0.
  - H and T = 0, so block_out = 0.
- Reset asserted mid-operation discards both entries without an output transfer.
- First valid edge after RST deasserts may accept data.
- Latency: a bundle accepted at edge k appears on block_out with valid_out = 1 after edge k when the FIFO was empty (one cycle).
- Throughput: one bundle per cycle when ready_in is held at 1.
- Stall: with ready_in = 0, the stage absorbs exactly two bundles. ready_out drops to 0 after the second acceptance.
- Recovery: one cycle with ready_in = 1 while full pops H and raises ready_out for the next cycle.
- block_out and valid_out must stay stable while valid_out = 1 and ready_in = 0.

## Test plan
- Reset values: drive RST = 0 at random mid-stream -> valid_out = 0, ready_out = 1, blk_count = 0, block_out = 0 within the same cycle, with no clock edge required.
- Arithmetic: a = 0x80000000, b = 0x00000001, c = d = 0, e = 0x00000001, then a single transfer -> block_out[31:0] = 0x8200E000, upper 160 bits equal to block_in, latency 1 cycle.
- Wrap-around: a = 0xFFFFFFFF, b = 0, e = 0x00000001 -> w_new = 0x00009FFF. Separately, 65536 output transfers -> blk_count returns to 0x0000.
- Backpressure:
  - Stimulus: ready_in = 0, three consecutive valid_in bundles X0, X1, X2.
  - Acceptance: X0 and X1 accepted; ready_out = 0 while X2 is presented; X2 held upstream.
  - Drain: release ready_in -> outputs X0, X1, X2 in order with no gaps after the first pop.
- Streaming: valid_in = ready_in = 1 for 100 cycles with random data -> 100 outputs matching the reference model in order, N never exceeds 1, blk_count = 100.
- Randomized handshake: random valid_in and ready_in at 50% each for 10k cycles -> scoreboard shows no loss, duplication or reordering, and block_out is stable during every stall.
